led_seg_out: RTL and testbench
==============================

// Module: led_seg_out
// PURPOSE
//  Memory-mapped output peripheral: CPU stores drive the 16 board LEDs and an 8-digit
//  multiplexed 7-segment display. Sits on the IO bus beside the switch input block and
//  is the write-side counterpart of its load decoding (separate address window).
//  Internally runs a digit-scan counter and hex-to-segment decoding.
// PARAMETERS
//  SCAN_DIV   100000        clk cycles each digit is lit; legal range >= 2
//  LED_ADDR   32'hFFFF_FFE1 store target for LED word
//  SEG_ADDR   32'hFFFF_FFE3 store target for 8-nibble display value
//  MASK_ADDR  32'hFFFF_FFE5 store target for digit blank mask (+ dp mask, see CONFIGURATION)
// PORTS
//  clk         in   1   system clock, all state on posedge
//  rst         in   1   asynchronous, active-high reset
//  LEDCtrl     in   1   IO decode select for LED window
//  SegCtrl     in   1   IO decode select for 7-seg windows
//  mem_write   in   1   store strobe, valid for one cycle
//  address     in   32  store address
//  write_data  in   32  store data
//  led_out     out  16  LED drive, active-high, registered
//  seg_an      out  8   digit anodes, active-low one-hot, registered
//  seg_code    out  8   segments {dp,g,f,e,d,c,b,a}, active-low, registered
// BEHAVIOUR
//  - Reset (async): led_out=16'h0000, value=32'h0, blank_mask=8'hFF, dp_mask=8'h00,
//    div_cnt=0, digit_idx=0, seg_an=8'hFF, seg_code=8'hFF.
//  - Write decode, posedge: LED write when mem_write&LEDCtrl&address==LED_ADDR ->
//    led_out<=write_data[15:0]; SEG write when mem_write&SegCtrl&address==SEG_ADDR ->
//    value<=write_data; MASK write when mem_write&SegCtrl&address==MASK_ADDR ->
//    blank_mask<=write_data[7:0]. Other addresses/ctrl combos: no state change.
//    Ctrl line set but address mismatched (e.g. LEDCtrl with SEG_ADDR) -> ignored.
//  - LED latency: led_out shows new word on the same edge the store is captured.
//  - Scan: div_cnt counts 0..SCAN_DIV-1 and wraps to 0; on div_cnt==SCAN_DIV-1,
//    digit_idx<=digit_idx+1 (3-bit, 7 wraps to 0). Each digit lit SCAN_DIV cycles.
//  - Output stage, every posedge from current (pre-edge) digit_idx/value/mask:
//    blank_mask[digit_idx]=1 -> seg_an<=8'hFF, seg_code<=8'hFF;
//    else seg_an<=~(8'b1<<digit_idx), seg_code<={dp_bit, hex7(value[4*idx+3:4*idx])}.
//    hex7 active-low, full 0-F: 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12
//    6=7'h02 7=7'h78 8=7'h00 9=7'h10 A=7'h08 b=7'h03 C=7'h46 d=7'h21 E=7'h06 F=7'h0E.
//  - Display latency: store captured at edge N -> seg outputs reflect it at edge N+1.
//    Digit change: digit_idx updates at edge N, seg_an follows at edge N+1.
//  - Writes mid-scan do not reset div_cnt or digit_idx.
//  - Exactly one anode low at any time, or none when blanked/reset.
//  - Reset asserted mid-scan: all state returns to reset values immediately; scan
//    restarts at digit 0 with full SCAN_DIV period after release.
// CONFIGURATION
//  SEG_DP_EN defined: MASK write also captures dp_mask<=write_data[15:8]; dp_bit =
//    ~dp_mask[digit_idx] (dp lit when mask bit set).
//  SEG_DP_EN undefined: no dp_mask register; dp_bit=1 always (dp off);
//    write_data[15:8] ignored.
// TESTING (bench uses SCAN_DIV=4)
//  1 Reset: rst=1 mid-run -> led_out=0000, seg_an=FF, seg_code=FF without a clk edge.
//  2 LED store 32'h0001_A5C3 @LED_ADDR with LEDCtrl -> led_out=A5C3 same edge; same
//    store with SegCtrl only -> led_out unchanged.
//  3 SEG 32'h7654_3210, MASK 8'h00 -> seg_an cycles FE,FD,...,7F, each 4 cycles;
//    seg_code C0,F9,A4,B0,99,92,82,F8; after 7F wraps to FE.
//  4 MASK 8'hF0, SEG 32'hFEDC_BA98 -> digits 4-7: seg_an=FF, seg_code=FF;
//    digits 0-3 show 80,90,88,83.
//  5 SEG store while digit 2 lit, value 0->32'h0000_0E00 -> seg_code C0->86 next edge,
//    seg_an stays FB, div_cnt not disturbed.
//  6 SEG_DP_EN: MASK 32'h0000_0100 -> digit 0 seg_code bit7=0, others bit7=1;
//    without macro bit7=1 on all digits.

Source files
------------

// File: rtl/led_seg_out.sv
// Memory-mapped LED / 8-digit multiplexed 7-segment output peripheral with digit scan and hex decoding.
// Optional per-digit decimal point mask enabled by defining SEG_DP_EN.
module led_seg_out #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter logic [31:0] LED_ADDR  = 32'hFFFF_FFE1,
  parameter logic [31:0] SEG_ADDR  = 32'hFFFF_FFE3,
  parameter logic [31:0] MASK_ADDR = 32'hFFFF_FFE5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LEDCtrl,
  input  logic        SegCtrl,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_code
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);

  logic          led_we, seg_we, mask_we;
  logic [31:0]   value;
  logic [7:0]    blank_mask;
  logic [CW-1:0] div_cnt;
  logic [2:0]    digit_idx;
  logic [3:0]    nib;
  logic          dp_bit;

  assign led_we  = mem_write & LEDCtrl & (address == LED_ADDR);
  assign seg_we  = mem_write & SegCtrl & (address == SEG_ADDR);
  assign mask_we = mem_write & SegCtrl & (address == MASK_ADDR);

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out    <= 16'h0000;
      value      <= 32'h0;
      blank_mask <= 8'hFF;
    end else begin
      if (led_we)  led_out    <= write_data[15:0];
      if (seg_we)  value      <= write_data;
      if (mask_we) blank_mask <= write_data[7:0];
    end
  end

`ifdef SEG_DP_EN
  logic [7:0] dp_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dp_mask <= 8'h00;
    else if (mask_we) dp_mask <= write_data[15:8];
  end

  // Active-low segment: a set mask bit lights the point.
  assign dp_bit = ~dp_mask[digit_idx];
`else
  assign dp_bit = 1'b1;
`endif

  // Scan timing is independent of stores so a write never restarts the current digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= 3'd0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

  assign nib = value[{digit_idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an   <= 8'hFF;
      seg_code <= 8'hFF;
    end else if (blank_mask[digit_idx]) begin
      seg_an   <= 8'hFF;
      seg_code <= 8'hFF;
    end else begin
      seg_an   <= ~(8'b1 << digit_idx);
      seg_code <= {dp_bit, hex7(nib)};
    end
  end

endmodule

// File: tb/tb_led_seg_out.sv
// Self-checking bench for led_seg_out (SCAN_DIV=4): reference model feeds a scoreboard queue
// each cycle; outputs are popped and compared one time unit after every rising edge.
module tb_led_seg_out;

  localparam logic [31:0] LED_A  = 32'hFFFF_FFE1;
  localparam logic [31:0] SEG_A  = 32'hFFFF_FFE3;
  localparam logic [31:0] MASK_A = 32'hFFFF_FFE5;

  logic        clk = 1'b0;
  logic        rst;
  logic        LEDCtrl, SegCtrl, mem_write;
  logic [31:0] address, write_data;
  logic [15:0] led_out;
  logic [7:0]  seg_an, seg_code;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] hex_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state
  int         m_cnt, m_dig;
  logic [31:0] m_val;
  logic [7:0]  m_blank, m_dp;
  logic [15:0] m_led;

  typedef struct { logic [7:0] an; logic [7:0] code; logic [15:0] led; } exp_t;
  exp_t sb[$];

  led_seg_out #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .LEDCtrl(LEDCtrl), .SegCtrl(SegCtrl), .mem_write(mem_write),
    .address(address), .write_data(write_data), .led_out(led_out), .seg_an(seg_an),
    .seg_code(seg_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_dig = 0; m_val = 32'h0; m_blank = 8'hFF; m_dp = 8'h00; m_led = 16'h0;
    sb.delete();
  endtask

  // One clock: predict from pre-edge model state and current inputs, then compare.
  task automatic step();
    exp_t e;
    logic [3:0] n;
    logic dpb;
    n = m_val[m_dig*4 +: 4];
`ifdef SEG_DP_EN
    dpb = ~m_dp[m_dig];
`else
    dpb = 1'b1;
`endif
    if (m_blank[m_dig]) begin
      e.an = 8'hFF; e.code = 8'hFF;
    end else begin
      e.an = ~(8'b1 << m_dig); e.code = {dpb, hex_t[n]};
    end
    if (mem_write && LEDCtrl && address == LED_A) m_led = write_data[15:0];
    e.led = m_led;
    sb.push_back(e);
    if (mem_write && SegCtrl && address == SEG_A) m_val = write_data;
    if (mem_write && SegCtrl && address == MASK_A) begin
      m_blank = write_data[7:0];
      m_dp    = write_data[15:8];
    end
    if (m_cnt == 3) begin m_cnt = 0; m_dig = (m_dig + 1) % 8; end
    else m_cnt++;
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk("seg_an", {8'h0, seg_an}, {8'h0, e.an});
      chk("seg_code", {8'h0, seg_code}, {8'h0, e.code});
      chk("led_out", led_out, e.led);
    end
  endtask

  task automatic wr(input logic lc, input logic sc, input logic [31:0] a, input logic [31:0] d);
    LEDCtrl = lc; SegCtrl = sc; mem_write = 1'b1; address = a; write_data = d;
    step();
    mem_write = 1'b0; LEDCtrl = 1'b0; SegCtrl = 1'b0; address = 32'h0; write_data = 32'h0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; LEDCtrl = 1'b0; SegCtrl = 1'b0; mem_write = 1'b0;
    address = 32'h0; write_data = 32'h0;
    model_reset();
    #2;
    chk("rst_led", led_out, 16'h0000);
    chk("rst_an", {8'h0, seg_an}, 16'h00FF);
    chk("rst_code", {8'h0, seg_code}, 16'h00FF);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    run(3);

    // LED window: proper select, wrong select, wrong address
    wr(1'b1, 1'b0, LED_A, 32'h0001_A5C3);
    chk("led_same_edge", led_out, 16'hA5C3);
    wr(1'b0, 1'b1, LED_A, 32'h0000_1234);
    chk("led_segctrl_ignored", led_out, 16'hA5C3);
    wr(1'b1, 1'b0, SEG_A, 32'h0000_5555);
    chk("led_wrong_addr", led_out, 16'hA5C3);
    LEDCtrl = 1'b1; address = LED_A; write_data = 32'h0000_FFFF; // no strobe
    step();
    LEDCtrl = 1'b0; address = 32'h0; write_data = 32'h0;
    chk("led_no_strobe", led_out, 16'hA5C3);

    // full scan of 76543210, no blanking
    wr(1'b0, 1'b1, SEG_A, 32'h7654_3210);
    wr(1'b0, 1'b1, MASK_A, 32'h0000_0000);
    run(40);

    // upper digits blanked, 98ABCDEF pattern
    wr(1'b0, 1'b1, MASK_A, 32'h0000_00F0);
    wr(1'b0, 1'b1, SEG_A, 32'hFEDC_BA98);
    run(36);

    // decimal point on digit 0 only
    wr(1'b0, 1'b1, MASK_A, 32'h0000_0100);
    run(34);

    // mid-digit store while digit 2 is lit
    wr(1'b0, 1'b1, SEG_A, 32'h0000_0000);
    wr(1'b0, 1'b1, MASK_A, 32'h0000_0000);
    for (int i = 0; i < 40 && !(m_dig == 2 && m_cnt == 1); i++) step();
    chk("d2_reached", 16'(m_dig * 4 + m_cnt), 16'd9);
    chk("d2_an_before", {8'h0, seg_an}, 16'h00FB);
    chk("d2_code_before", {8'h0, seg_code & 8'h7F}, 16'h0040);
    wr(1'b0, 1'b1, SEG_A, 32'h0000_0E00);
    chk("d2_code_hold", {8'h0, seg_code & 8'h7F}, 16'h0040);
    step();
    chk("d2_an_after", {8'h0, seg_an}, 16'h00FB);
    chk("d2_code_after", {8'h0, seg_code & 8'h7F}, 16'h0006);
    run(20);

    // asynchronous reset mid-scan, then restart from digit 0
    rst = 1'b1;
    #1;
    chk("arst_led", led_out, 16'h0000);
    chk("arst_an", {8'h0, seg_an}, 16'h00FF);
    chk("arst_code", {8'h0, seg_code}, 16'h00FF);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    wr(1'b0, 1'b1, MASK_A, 32'h0000_0000);
    run(12);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
